// File: rtl/pc_redirect_ctrl_if.sv
//------------------------------------------------------------------------------
// pc_redirect_ctrl_if : fetch request channel between the PC controller and
//                       instruction memory (valid/ready plus stale-response kill)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_redirect_ctrl_if;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc;
   logic        drop_resp;

   modport master (
      output fetch_valid,
      output fetch_pc,
      output drop_resp,
      input  fetch_ready
   );

   modport slave (
      input  fetch_valid,
      input  fetch_pc,
      input  drop_resp,
      output fetch_ready
   );
endinterface

`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
//------------------------------------------------------------------------------
// pc_redirect_ctrl : fetch PC owner; sequences EX-stage redirects, flush and
//                    stale-response drop. Optional macro: PC_MISALIGN_TRAP_EN
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic [4:0]        branch_type,
   input  wire logic              ex_valid,
   input  wire logic [31:0]       ex_pc,
   input  wire logic [31:0]       ex_imm,
   input  wire logic [31:0]       ex_rs1,
   input  wire logic              stall,
   pc_redirect_ctrl_if.master     fetch_if,
   output      logic              flush,
   output      logic              onehot_err,
   output      logic              trap
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] pend_q, pend_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic        drop_q, drop_d;
   logic        err_q, err_d;

   logic        bt_onehot;
   logic        redir;
   logic        accept;
   logic [31:0] br_target;
   logic [31:0] jalr_target;
   logic [31:0] raw_target;
   logic [31:0] target;

   always_comb begin
      bt_onehot   = (branch_type != 5'd0) &&
                    ((branch_type & (branch_type - 5'd1)) == 5'd0);
      redir       = ex_valid & bt_onehot & (|branch_type[3:1]);
      br_target   = ex_pc + ex_imm;
      jalr_target = (ex_rs1 + ex_imm) & ~32'h1;
      raw_target  = branch_type[3] ? jalr_target : br_target;
   end

`ifdef PC_MISALIGN_TRAP_EN
   logic misalign;
   always_comb begin
      misalign = |raw_target[1:0];
      target   = misalign ? TRAP_VEC : raw_target;
      trap     = redir & misalign;
   end
`else
   logic unused_misalign_bits;
   always_comb begin
      target               = {raw_target[31:2], 2'b00};
      trap                 = 1'b0;
      unused_misalign_bits = ^{TRAP_VEC, raw_target[1:0]};
   end
`endif

   always_comb begin
      accept     = fetch_valid_q & fetch_if.fetch_ready;
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_d     = pend_q;
      drop_d     = 1'b0;
      err_d      = err_q | (ex_valid & ~bt_onehot);

      case (state_q)
         BOOT: begin
            state_d = RUN;
            if (redir) fetch_pc_d = target;
         end
         RUN: begin
            if (redir) begin
               // Address must stay stable until imem takes it, so park the target.
               if (fetch_valid_q && !fetch_if.fetch_ready) begin
                  pend_d  = target;
                  state_d = WAIT;
               end else begin
                  fetch_pc_d = target;
                  drop_d     = accept;
               end
            end else if (accept && !stall) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
         WAIT: begin
            if (redir) pend_d = target;
            if (fetch_if.fetch_ready) begin
               fetch_pc_d = redir ? target : pend_q;
               drop_d     = 1'b1;
               state_d    = RUN;
            end
         end
         default: state_d = BOOT;
      endcase

      fetch_valid_d = (state_d != BOOT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= BOOT;
         fetch_pc_q    <= RESET_PC;
         pend_q        <= 32'd0;
         fetch_valid_q <= 1'b0;
         drop_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         pend_q        <= pend_d;
         fetch_valid_q <= fetch_valid_d;
         drop_q        <= drop_d;
         err_q         <= err_d;
      end
   end

   assign fetch_if.fetch_valid = fetch_valid_q;
   assign fetch_if.fetch_pc    = fetch_pc_q;
   assign fetch_if.drop_resp   = drop_q;
   assign flush                = redir;
   assign onehot_err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
//------------------------------------------------------------------------------
// tb_pc_redirect_ctrl : directed-vector bench for pc_redirect_ctrl
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  branch_type;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic [31:0] ex_rs1;
   logic        stall;
   logic        flush;
   logic        onehot_err;
   logic        trap;

   int n_vec = 0;
   int n_err = 0;

   pc_redirect_ctrl_if fif ();

   pc_redirect_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .branch_type (branch_type),
      .ex_valid    (ex_valid),
      .ex_pc       (ex_pc),
      .ex_imm      (ex_imm),
      .ex_rs1      (ex_rs1),
      .stall       (stall),
      .fetch_if    (fif.master),
      .flush       (flush),
      .onehot_err  (onehot_err),
      .trap        (trap)
   );

   always #5 clk = ~clk;

`ifdef PC_MISALIGN_TRAP_EN
   localparam logic EXP_TRAP = 1'b1;
`else
   localparam logic EXP_TRAP = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic ex_drive(input logic v, input logic [4:0] bt, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] rs1);
      ex_valid    = v;
      branch_type = bt;
      ex_pc       = pc;
      ex_imm      = imm;
      ex_rs1      = rs1;
   endtask

   task automatic ex_idle();
      ex_drive(1'b0, 5'b00001, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] pc, input logic drop);
      check({tag, "_pc"}, fif.fetch_pc, pc);
      check({tag, "_drop"}, {31'd0, fif.drop_resp}, {31'd0, drop});
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      fif.fetch_ready = 1'b1;
      ex_idle();

      // Reset state
      tick();
      tick();
      check("rst_valid", {31'd0, fif.fetch_valid}, 32'd0);
      chk_fetch("rst", 32'h0, 1'b0);
      check("rst_err", {31'd0, onehot_err}, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      rst = 1'b0;

      // BOOT cycle, then sequential fetch
      tick();
      check("boot_valid", {31'd0, fif.fetch_valid}, 32'd1);
      chk_fetch("seq0", 32'h0, 1'b0);
      tick();
      chk_fetch("seq1", 32'h4, 1'b0);
      tick();
      chk_fetch("seq2", 32'h8, 1'b0);

      // jal taken, imem ready
      ex_drive(1'b1, 5'b00100, 32'h40, 32'h20, 32'h0);
      settle();
      check("jal_flush", {31'd0, flush}, 32'd1);
      tick();
      ex_idle();
      settle();
      chk_fetch("jal_tgt", 32'h60, 1'b1);
      check("jal_flush_off", {31'd0, flush}, 32'd0);
      tick();
      chk_fetch("jal_next", 32'h64, 1'b0);

      // jalr while imem not ready for 3 cycles
      fif.fetch_ready = 1'b0;
      ex_drive(1'b1, 5'b01000, 32'h64, 32'h4, 32'h1001);
      settle();
      check("jalr_flush", {31'd0, flush}, 32'd1);
      tick();
      ex_idle();
      chk_fetch("wait0", 32'h64, 1'b0);
      check("wait0_valid", {31'd0, fif.fetch_valid}, 32'd1);
      tick();
      chk_fetch("wait1", 32'h64, 1'b0);
      tick();
      chk_fetch("wait2", 32'h64, 1'b0);
      fif.fetch_ready = 1'b1;
      tick();
      chk_fetch("jalr_tgt", 32'h1004, 1'b1);
      tick();
      chk_fetch("jalr_next", 32'h1008, 1'b0);

      // Taken branch with stall: redirect wins; target add drops the carry
      stall = 1'b1;
      ex_drive(1'b1, 5'b00010, 32'h200, 32'hFFFF_FFF0, 32'h0);
      settle();
      check("bst_flush", {31'd0, flush}, 32'd1);
      tick();
      ex_idle();
      chk_fetch("bst_tgt", 32'h1F0, 1'b1);
      tick();
      chk_fetch("stall_hold", 32'h1F0, 1'b0);
      stall = 1'b0;
      tick();
      chk_fetch("stall_rel", 32'h1F4, 1'b0);

      // Misaligned btype target 0x102
      ex_drive(1'b1, 5'b00010, 32'h100, 32'h2, 32'h0);
      settle();
      check("mis_flush", {31'd0, flush}, 32'd1);
      check("mis_trap", {31'd0, trap}, {31'd0, EXP_TRAP});
      tick();
      ex_idle();
      settle();
      chk_fetch("mis_tgt", 32'h100, 1'b1);
      check("mis_trap_off", {31'd0, trap}, 32'd0);
      tick();
      chk_fetch("mis_next", 32'h104, 1'b0);

      // Non-one-hot branch_type: sequential, sticky error
      ex_drive(1'b1, 5'b00110, 32'h104, 32'h80, 32'h0);
      settle();
      check("noh_flush", {31'd0, flush}, 32'd0);
      tick();
      chk_fetch("noh_pc", 32'h108, 1'b0);
      check("noh_err", {31'd0, onehot_err}, 32'd1);

      // ex_valid=0 ignores branch_type
      ex_drive(1'b0, 5'b00100, 32'h108, 32'h40, 32'h0);
      settle();
      check("inv_flush", {31'd0, flush}, 32'd0);
      tick();
      chk_fetch("inv_pc", 32'h10C, 1'b0);
      check("err_sticky", {31'd0, onehot_err}, 32'd1);

      // jal to top of address space, then wrap
      ex_drive(1'b1, 5'b00100, 32'hFFFF_FFF0, 32'hC, 32'h0);
      tick();
      ex_idle();
      chk_fetch("top_tgt", 32'hFFFF_FFFC, 1'b1);
      tick();
      chk_fetch("wrap", 32'h0, 1'b0);
      tick();
      chk_fetch("wrap_next", 32'h4, 1'b0);

      // Not ready without redirect: address held
      fif.fetch_ready = 1'b0;
      tick();
      chk_fetch("hold", 32'h4, 1'b0);

      // Redirect into WAIT, then reset mid-WAIT discards the pending target
      ex_drive(1'b1, 5'b00100, 32'h40, 32'h20, 32'h0);
      tick();
      ex_idle();
      chk_fetch("w2_hold", 32'h4, 1'b0);
      rst = 1'b1;
      tick();
      check("rst2_valid", {31'd0, fif.fetch_valid}, 32'd0);
      chk_fetch("rst2", 32'h0, 1'b0);
      check("rst2_err", {31'd0, onehot_err}, 32'd0);
      rst = 1'b0;
      fif.fetch_ready = 1'b1;
      tick();
      check("boot2_valid", {31'd0, fif.fetch_valid}, 32'd1);
      chk_fetch("boot2", 32'h0, 1'b0);
      tick();
      chk_fetch("boot2_next", 32'h4, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Owns the fetch program counter and sequences redirects produced by the EX-stage branch resolver.
- Consumes the resolver's one-hot branch_type and computes the next fetch address.
- Enforces the valid/ready fetch handshake toward instruction memory.
- Generates the IF/ID flush and the kill of stale fetch responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address driven after reset.
- TRAP_VEC, 32'h0000_0100, redirect target on misaligned branch target (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- branch_type  in  5  one-hot {auipc, jalr, jal, btype_taken, pc4} from the EX resolver
- ex_valid  in  1  EX stage holds a valid instruction
- ex_pc  in  32  PC of the EX instruction
- ex_imm  in  32  sign-extended immediate of the EX instruction
- ex_rs1  in  32  forwarded rs1 value
- stall  in  1  hazard-unit stall; freezes PC advance
- fetch_ready  in  1  imem accepts the request
- fetch_valid  out  1  fetch request valid
- fetch_pc  out  32  fetch address
- flush  out  1  kill the IF/ID and ID/EX instructions
- drop_resp  out  1  next imem response belongs to a superseded fetch; discard it
- onehot_err  out  1  sticky: branch_type seen not one-hot while ex_valid
- trap  out  1  misaligned-target pulse (optional feature only; tied 0 otherwise)

Behaviour:
- States: BOOT, RUN, WAIT.
- Reset (any state, any cycle):
  - state=BOOT, fetch_pc=RESET_PC, fetch_valid=0.
  - flush=0, drop_resp=0, onehot_err=0, trap=0.
  - Any latched pending target is discarded.
- BOOT: one cycle with fetch_valid=0, then RUN.
- RUN: fetch_valid=1.
- Handshake:
  - Fetch accepted on a cycle with fetch_valid & fetch_ready.
  - fetch_pc must not change while fetch_valid=1 and fetch_ready=0.
- Sequential advance: on an accepted fetch with no redirect and stall=0, fetch_pc <= fetch_pc+4 on the next edge, wrapping mod 2^32.
- Stall: an accepted fetch does not advance fetch_pc. The same address is re-requested.
- Redirect:
  - redir = ex_valid & (branch_type[1] | branch_type[2] | branch_type[3]).
  - Targets:
    - btype/jal: ex_pc+ex_imm.
    - jalr: (ex_rs1+ex_imm) & ~32'h1.
  - 32-bit adds; carry dropped.
  - auipc and pc4 are sequential and cause no redirect.
  - Redirect has priority over stall.
- Redirect in RUN:
  - flush=1 combinationally in the same cycle.
  - If fetch_valid=1 and fetch_ready=0: latch the target into the pending register, state <= WAIT, fetch_pc held.
  - Otherwise: fetch_pc <= target on the next edge.
  - If a fetch is accepted in the redirect cycle: drop_resp=1 for the following cycle, because the in-flight response is stale.
- WAIT:
  - fetch_valid=1 with the old address.
  - When fetch_ready=1: fetch_pc <= pending target, drop_resp=1 next cycle, state <= RUN.
  - A new redir in WAIT (ex_valid is illegal post-flush, but tolerated) overwrites the pending target and asserts flush.
- Non-one-hot branch_type with ex_valid=1:
  - Treated as pc4 (no redirect).
  - onehot_err set and held until rst.
- ex_valid=0: branch_type is ignored.
- flush is 0 when no redirect is made in the cycle.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect target with target[1:0] != 0 does not redirect to that target.
  - trap=1 for one cycle and flush=1.
  - The redirect uses TRAP_VEC in place of the target, with the same WAIT/drop rules.
- Undefined:
  - target[1:0] is forced to 2'b00.
  - trap is tied 0.

Test Plan:
- Reset release, fetch_ready=1 continuously -> BOOT cycle fetch_valid=0; then fetch_pc 0x0, 0x4, 0x8, one per cycle.
- jal taken (branch_type=5'b00100, ex_pc=0x40, ex_imm=0x20, fetch_ready=1) -> flush=1 same cycle; next fetch_pc=0x60; drop_resp=1 one cycle.
- jalr (ex_rs1=0x1001, ex_imm=0x4, branch_type=5'b01000) while fetch_ready=0 for 3 cycles:
  - fetch_pc stays at the old value, state WAIT.
  - On ready, the following fetch_pc=0x1004 and drop_resp=1.
- Taken branch with stall=1 simultaneously -> redirect applied (fetch_pc=target); stall does not block it.
- branch_type=5'b00110 with ex_valid=1 -> no redirect, onehot_err=1 and stays 1 until rst pulse; rst mid-WAIT -> fetch_pc=RESET_PC, state BOOT.
- PC_MISALIGN_TRAP_EN defined, btype target 0x102 -> trap=1 one cycle, fetch_pc=TRAP_VEC. Undefined, same stimulus -> fetch_pc=0x100.
